// File: rtl/mul_div_sequencer.sv
// mul_div_sequencer: execute-stage multiply/divide sequencer.
// Two-cycle multiply/accumulate and a restoring divide feeding HILO.
module mul_div_sequencer #(
  parameter int DIV_ITERS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic [63:0] hilo_i,
  input  logic        flush,
  output logic        stall_o,
  output logic [63:0] result_o,
  output logic        hilo_wen_o
);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [63:0] hilo_q, hilo_d;
  logic [63:0] acc_q, acc_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;

  logic        accept;
  logic        is_div;
  logic        is_sdiv;
  logic        b_zero;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [63:0] ext_a;
  logic [63:0] ext_b;
  logic [63:0] prod;
  logic [64:0] shifted;
  logic [32:0] trial;
  logic [31:0] rem_out;
  logic [31:0] quo_out;

  assign accept  = (state_q == IDLE) && start && !flush;
  assign is_div  = (op[2:1] == 2'b01);
  assign is_sdiv = (op == 3'b010);
  assign b_zero  = (src_b == 32'h0);
  assign abs_a   = (is_sdiv && src_a[31]) ? -src_a : src_a;
  assign abs_b   = (is_sdiv && src_b[31]) ? -src_b : src_b;

  // Sign-extend only for the signed variants so one 64x64 product
  // truncated to 64 bits serves both signed and unsigned multiplies.
  assign ext_a = {{32{a_q[31] & ~op_q[0]}}, a_q};
  assign ext_b = {{32{b_q[31] & ~op_q[0]}}, b_q};
  assign prod  = ext_a * ext_b;

  // acc_q holds {rem,quo}; the trial subtract looks at the upper 33 bits
  assign shifted = {acc_q, 1'b0};
  assign trial   = shifted[64:32] - {1'b0, b_q};

  assign rem_out = rneg_q ? -acc_q[63:32] : acc_q[63:32];
  assign quo_out = qneg_q ? -acc_q[31:0] : acc_q[31:0];

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hilo_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hilo_q  <= hilo_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
    end
  end

  // Next-state: flush wins from any state
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            if (!is_div)     state_d = MUL;
            else if (b_zero) state_d = DONE;
            else             state_d = DIV;
          end
        end
        MUL:  state_d = DONE;
        DIV: begin
          if (cnt_q == 6'(DIV_ITERS - 1)) state_d = DONE;
        end
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Operand capture, multiply register and one divide step per cycle
  always_comb begin
    op_d   = op_q;
    a_d    = a_q;
    b_d    = b_q;
    hilo_d = hilo_q;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    if (accept) begin
      op_d   = op;
      a_d    = src_a;
      b_d    = is_div ? abs_b : src_b;
      hilo_d = hilo_i;
      cnt_d  = '0;
      qneg_d = is_sdiv & ~b_zero & (src_a[31] ^ src_b[31]);
      rneg_d = is_sdiv & ~b_zero & src_a[31];
      // divide-by-zero result is preloaded so DONE just passes it out
      if (is_div && b_zero) acc_d = {src_a, 32'hFFFF_FFFF};
      else                  acc_d = {32'h0, abs_a};
    end else if (state_q == MUL) begin
      acc_d = prod;
    end else if (state_q == DIV) begin
      cnt_d = cnt_q + 6'd1;
      if (!trial[32]) acc_d = {trial[31:0], shifted[31:1], 1'b1};
      else            acc_d = {shifted[63:32], shifted[31:1], 1'b0};
    end
  end

  // Outputs: stall, write strobe and the final HILO value
  always_comb begin
    stall_o    = accept || (state_q == MUL) || (state_q == DIV);
    hilo_wen_o = (state_q == DONE) && !flush;
    result_o   = '0;
    if (state_q == DONE) begin
      unique case (op_q[2:1])
        2'b00: result_o = acc_q;
        2'b01: result_o = {rem_out, quo_out};
        2'b10: result_o = hilo_q + acc_q;
        2'b11: result_o = hilo_q - acc_q;
        default: result_o = acc_q;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_sequencer.sv
// tb_mul_div_sequencer: scoreboard bench for the MDU sequencer.
// Expected HILO values come from a behavioural model at issue time.
module tb_mul_div_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [63:0] hilo_i;
  logic        flush;
  logic        stall_o;
  logic [63:0] result_o;
  logic        hilo_wen_o;

  int          vecs = 0;
  int          errs = 0;
  int unsigned tick = 0;
  logic [63:0] sb_q[$];

  mul_div_sequencer #(.DIV_ITERS(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .op         (op),
    .src_a      (src_a),
    .src_b      (src_b),
    .hilo_i     (hilo_i),
    .flush      (flush),
    .stall_o    (stall_o),
    .result_o   (result_o),
    .hilo_wen_o (hilo_wen_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) tick <= tick + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] model(input logic [2:0] o,
                                        input logic [31:0] a,
                                        input logic [31:0] b,
                                        input logic [63:0] h);
    longint      sa;
    longint      sbv;
    logic [63:0] p;
    int          q;
    int          r;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    if (o[0]) p = {32'h0, a} * {32'h0, b};
    else      p = sa * sbv;
    case (o)
      3'b000, 3'b001: return p;
      3'b100, 3'b101: return h + p;
      3'b110, 3'b111: return h - p;
      3'b010: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
          return {32'h0, 32'h8000_0000};
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {r, q};
      end
      default: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  task automatic issue(input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [63:0] h,
                       input bit track);
    start  = 1'b1;
    op     = o;
    src_a  = a;
    src_b  = b;
    hilo_i = h;
    if (track) sb_q.push_back(model(o, a, b, h));
  endtask

  task automatic quiet();
    start = 1'b0;
    flush = 1'b0;
  endtask

  // Runs from the accept cycle until the first strobe; no checking here.
  task automatic run_to_wen(input int max, output int cyc, output int nst,
                            output logic [63:0] res, output int unsigned at);
    cyc = -1;
    nst = 0;
    res = '0;
    at  = 0;
    for (int c = 0; c <= max; c++) begin
      @(negedge clk);
      if (stall_o) nst++;
      if (hilo_wen_o) begin
        cyc = c;
        res = result_o;
        at  = tick;
      end
      @(posedge clk);
      #1;
      if (cyc >= 0) break;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    quiet();
    op = '0; src_a = '0; src_b = '0; hilo_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vecs++;
    if (stall_o !== 1'b0) begin
      errs++; $display("FAIL rst_stall: got %b want 0", stall_o);
    end
    vecs++;
    if (hilo_wen_o !== 1'b0) begin
      errs++; $display("FAIL rst_wen: got %b want 0", hilo_wen_o);
    end
    vecs++;
    if (result_o !== 64'h0) begin
      errs++; $display("FAIL rst_result: got %h want 0", result_o);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_mult();
    logic [2:0]  ops[8] = '{3'b000, 3'b001, 3'b000, 3'b100,
                            3'b101, 3'b110, 3'b111, 3'b001};
    logic [31:0] as[8]  = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h7FFF_FFFF,
                            32'h8000_0000, 32'h1, 32'h1, 32'hFFFF_FFFF,
                            32'h0001_0000};
    logic [31:0] bs[8]  = '{32'h5, 32'hFFFF_FFFF, 32'h8000_0000,
                            32'h3, 32'h1, 32'h1, 32'h2, 32'h0001_0000};
    logic [63:0] hs[8]  = '{64'h0, 64'h0, 64'h0, 64'h0000_0010_0000_0000,
                            64'h0000_0001_FFFF_FFFF, 64'h0,
                            64'h1234_5678_9ABC_DEF0, 64'h0};
    int          cyc;
    int          nst;
    int unsigned at;
    logic [63:0] res;
    logic [63:0] exp;
    for (int i = 0; i < 12; i++) begin
      if (i < 8) begin
        issue(ops[i], as[i], bs[i], hs[i], 1'b1);
      end else begin
        logic [2:0] ro;
        ro = 3'($urandom_range(0, 5));
        if (ro >= 3'd2) ro = ro + 3'd2;
        issue(ro, $urandom, $urandom, {$urandom, $urandom}, 1'b1);
      end
      run_to_wen(8, cyc, nst, res, at);
      exp = sb_q.pop_front();
      vecs++;
      if (cyc !== 2) begin
        errs++; $display("FAIL mul_lat[%0d]: got %0d want 2", i, cyc);
      end
      vecs++;
      if (nst !== 2) begin
        errs++; $display("FAIL mul_stall[%0d]: got %0d want 2", i, nst);
      end
      vecs++;
      if (res !== exp) begin
        errs++; $display("FAIL mul_res[%0d]: got %h want %h", i, res, exp);
      end
      quiet();
    end
  endtask

  task automatic test_div();
    logic [2:0]  ops[4] = '{3'b011, 3'b010, 3'b010, 3'b011};
    logic [31:0] as[4]  = '{32'd100, 32'hFFFF_FFF9, 32'h8000_0000,
                            32'hFFFF_FFFF};
    logic [31:0] bs[4]  = '{32'd7, 32'd2, 32'hFFFF_FFFF, 32'h1};
    int          cyc;
    int          nst;
    int unsigned at;
    logic [63:0] res;
    logic [63:0] exp;
    logic [31:0] ra;
    logic [31:0] rb;
    for (int i = 0; i < 10; i++) begin
      if (i < 4) begin
        issue(ops[i], as[i], bs[i], 64'h0, 1'b1);
      end else begin
        ra = $urandom;
        rb = $urandom >> $urandom_range(0, 28);
        if (rb == 32'h0) rb = 32'h3;
        issue({2'b01, 1'(i & 1)}, ra, rb, {$urandom, $urandom}, 1'b1);
      end
      run_to_wen(40, cyc, nst, res, at);
      exp = sb_q.pop_front();
      vecs++;
      if (cyc !== 33) begin
        errs++; $display("FAIL div_lat[%0d]: got %0d want 33", i, cyc);
      end
      vecs++;
      if (nst !== 33) begin
        errs++; $display("FAIL div_stall[%0d]: got %0d want 33", i, nst);
      end
      vecs++;
      if (res !== exp) begin
        errs++; $display("FAIL div_res[%0d]: got %h want %h", i, res, exp);
      end
      quiet();
    end
  endtask

  task automatic test_div_zero();
    int          cyc;
    int          nst;
    int unsigned at;
    logic [63:0] res;
    logic [63:0] exp;
    for (int i = 0; i < 2; i++) begin
      issue(i == 0 ? 3'b010 : 3'b011, i == 0 ? 32'h1234 : 32'hDEAD_BEEF,
            32'h0, 64'h0, 1'b1);
      run_to_wen(40, cyc, nst, res, at);
      exp = sb_q.pop_front();
      vecs++;
      if (cyc !== 1) begin
        errs++; $display("FAIL dz_lat[%0d]: got %0d want 1", i, cyc);
      end
      vecs++;
      if (nst !== 1) begin
        errs++; $display("FAIL dz_stall[%0d]: got %0d want 1", i, nst);
      end
      vecs++;
      if (res !== exp) begin
        errs++; $display("FAIL dz_res[%0d]: got %h want %h", i, res, exp);
      end
      quiet();
    end
  endtask

  task automatic test_flush_div();
    int          cyc;
    int          nst;
    int unsigned at;
    logic [63:0] res;
    logic [63:0] exp;
    int          wen_seen;
    int          low_stall;
    for (int pass = 0; pass < 2; pass++) begin
      wen_seen  = 0;
      low_stall = 0;
      issue(3'b011, 32'h0FFF_FFFF, 32'h3, 64'h0, 1'b0);
      for (int c = 0; c <= 10; c++) begin
        if (c == 10) flush = 1'b1;
        @(negedge clk);
        if (hilo_wen_o) wen_seen++;
        if (!stall_o) low_stall++;
        @(posedge clk);
        #1;
      end
      quiet();
      if (pass == 0) begin
        @(negedge clk);
        vecs++;
        if (stall_o !== 1'b0) begin
          errs++; $display("FAIL flush_stall11: got %b want 0", stall_o);
        end
        for (int c = 0; c < 40; c++) begin
          @(negedge clk);
          if (hilo_wen_o) wen_seen++;
        end
        @(posedge clk);
        #1;
      end else begin
        issue(3'b000, 32'hFFFF_FFF0, 32'h7, 64'h0, 1'b1);
        run_to_wen(40, cyc, nst, res, at);
        exp = sb_q.pop_front();
        quiet();
        vecs++;
        if (cyc !== 2) begin
          errs++; $display("FAIL flush_mul_lat: got %0d want 2", cyc);
        end
        vecs++;
        if (res !== exp) begin
          errs++; $display("FAIL flush_mul_res: got %h want %h", res, exp);
        end
      end
      vecs++;
      if (wen_seen !== 0) begin
        errs++; $display("FAIL flush_wen[%0d]: got %0d want 0", pass, wen_seen);
      end
      vecs++;
      if (low_stall !== 0) begin
        errs++;
        $display("FAIL flush_busy[%0d]: low %0d want 0", pass, low_stall);
      end
    end
  endtask

  task automatic test_flush_done();
    int wen_seen;
    for (int i = 0; i < 2; i++) begin
      wen_seen = 0;
      if (i == 0) issue(3'b010, 32'h55, 32'h0, 64'h0, 1'b0);
      else        issue(3'b000, 32'h3, 32'h4, 64'h0, 1'b0);
      for (int c = 0; c < 1 + i; c++) begin
        @(negedge clk);
        if (hilo_wen_o) wen_seen++;
        @(posedge clk);
        #1;
      end
      flush = 1'b1;
      @(negedge clk);
      vecs++;
      if (hilo_wen_o !== 1'b0) begin
        errs++; $display("FAIL flush_done_wen[%0d]: got %b want 0", i, hilo_wen_o);
      end
      @(posedge clk);
      #1;
      quiet();
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        if (hilo_wen_o) wen_seen++;
      end
      vecs++;
      if (wen_seen !== 0) begin
        errs++; $display("FAIL flush_done_late[%0d]: got %0d want 0", i, wen_seen);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_back_to_back();
    int          c1;
    int          c2;
    int          nst;
    int unsigned at1;
    int unsigned at2;
    logic [63:0] r1;
    logic [63:0] r2;
    logic [63:0] e1;
    logic [63:0] e2;
    issue(3'b000, 32'hFFFF_8000, 32'h0003_0001, 64'h0, 1'b1);
    run_to_wen(8, c1, nst, r1, at1);
    e1 = sb_q.pop_front();
    issue(3'b100, 32'h1234_5678, 32'hFFFF_FFFE, e1, 1'b1);
    run_to_wen(8, c2, nst, r2, at2);
    e2 = sb_q.pop_front();
    quiet();
    vecs++;
    if (r1 !== e1) begin
      errs++; $display("FAIL b2b_first: got %h want %h", r1, e1);
    end
    vecs++;
    if (r2 !== e2) begin
      errs++; $display("FAIL b2b_madd: got %h want %h", r2, e2);
    end
    vecs++;
    if (c1 < 0 || c2 < 0 || at2 - at1 !== 32'd3) begin
      errs++;
      $display("FAIL b2b_gap: got %0d (c1 %0d c2 %0d) want 3", at2 - at1, c1, c2);
    end
  endtask

  task automatic test_reset_mid();
    int wen_seen = 0;
    issue(3'b010, 32'hF000_0000, 32'h7, 64'h0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (hilo_wen_o) wen_seen++;
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    quiet();
    @(negedge clk);
    vecs++;
    if ({stall_o, hilo_wen_o, result_o} !== 66'h0) begin
      errs++;
      $display("FAIL rst_mid_out: got %b %b %h want 0 0 0",
               stall_o, hilo_wen_o, result_o);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (hilo_wen_o) wen_seen++;
    end
    vecs++;
    if (wen_seen !== 0) begin
      errs++; $display("FAIL rst_mid_wen: got %0d want 0", wen_seen);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_flush_div();
    test_flush_done();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
